m3_m4_skid_queue: RTL

Parametrised successor to the fixed M3→M4 stage register. A DEPTH-entry elastic buffer with a valid/ready handshake on both sides, synchronous flush, and bubble collapsing: invalid slots are never stored. It carries {instruction_type, pc, result, rob_id} from the M3 stage to M4. An M4 stall back-pressures M3 through in_ready instead of relying on the older stall/valid rewrite.

---
 rtl/m3m4_pkg.sv | 26 ++
 rtl/sync_fifo_core.sv | 42 ++++
 rtl/m3_m4_skid_queue.sv | 47 ++++
 3 files changed

// File: rtl/m3m4_pkg.sv
// m3m4_pkg: shared M3->M4 payload struct, default widths and pointer-width helper
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 3
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 3
`endif
package m3m4_pkg;
  localparam int P_WORD_SIZE = `WORD_SIZE;
  localparam int P_INSTR_TYPE_SZ = `INSTR_TYPE_SZ;
  localparam int P_ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH;
  localparam int P_DEPTH = 2;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  localparam int PTR_W = ptr_w(P_DEPTH);
  typedef struct packed {
    logic [P_INSTR_TYPE_SZ-1:0] instr_type;
    logic [P_WORD_SIZE-1:0] pc;
    logic [P_WORD_SIZE-1:0] result;
    logic [P_ROB_ENTRY_WIDTH-1:0] rob_id;
  } m3m4_payload_t;
endpackage

// File: rtl/sync_fifo_core.sv
// sync_fifo_core: WIDTH x DEPTH circular buffer; clk/reset, clear (drops same-cycle push, keeps storage), push/wdata, pop/rdata, count
module sync_fifo_core import m3m4_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = ptr_w(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push && !clear) mem_d[wr_ptr_q] = wdata;
    wr_ptr_d = clear ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = clear ? '0 : rd_ptr_q + PW'(pop);
    count_d = clear ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/m3_m4_skid_queue.sv
// m3_m4_skid_queue: M3->M4 elastic queue; in_valid/in_ready + in_* payload, out_valid/out_ready + masked out_* payload, flush, count
module m3_m4_skid_queue import m3m4_pkg::*; #(
  parameter int WORD_SIZE = P_WORD_SIZE,
  parameter int INSTR_TYPE_SZ = P_INSTR_TYPE_SZ,
  parameter int ROB_ENTRY_WIDTH = P_ROB_ENTRY_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_TYPE_SZ-1:0]   in_instruction_type,
  input  logic [WORD_SIZE-1:0]       in_pc,
  input  logic [WORD_SIZE-1:0]       in_result,
  input  logic [ROB_ENTRY_WIDTH-1:0] in_rob_id,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_TYPE_SZ-1:0]   out_instruction_type,
  output logic [WORD_SIZE-1:0]       out_pc,
  output logic [WORD_SIZE-1:0]       out_result,
  output logic [ROB_ENTRY_WIDTH-1:0] out_rob_id,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int CW = $clog2(DEPTH) + 1;
  m3m4_payload_t wr_payload, head;
  logic push, pop;
  assign in_ready = count != CW'(DEPTH);
  assign out_valid = count != '0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign wr_payload = '{instr_type: in_instruction_type, pc: in_pc, result: in_result, rob_id: in_rob_id};
  sync_fifo_core #(.WIDTH($bits(m3m4_payload_t)), .DEPTH(DEPTH)) u_core (
    .clk(clk),
    .reset(reset),
    .clear(flush),
    .push(push),
    .pop(pop),
    .wdata(wr_payload),
    .rdata(head),
    .count(count)
  );
  assign out_instruction_type = out_valid ? head.instr_type : '0;
  assign out_pc = out_valid ? head.pc : '0;
  assign out_result = out_valid ? head.result : '0;
  assign out_rob_id = out_valid ? head.rob_id : '0;
endmodule
